// File: rtl/sprite_pixel_fetch_pkg.sv
// Shared constants and types for the sprite pixel fetch pipeline.
// Optional feature macro: SPRITE_TRANSPARENCY_EN (all-zero ROM words are see-through).
package sprite_pixel_fetch_pkg;

    localparam int H_RES         = 640;
    localparam int SPR_W         = 30;
    localparam int SPR_H         = 30;
    localparam int ORIENT_STRIDE = SPR_W * SPR_H;

    localparam logic [31:0] TRANSPARENT_KEY = '0;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } frame_state_t;

endpackage

// File: rtl/sprite_addr_map.sv
// Stage-0 combinational math: screen address -> sprite row/col, hit test and ROM address.
// The left-edge clip stops a sprite near the right border wrapping onto the next row.
module sprite_addr_map
    import sprite_pixel_fetch_pkg::*;
#(
    parameter int H_RES  = sprite_pixel_fetch_pkg::H_RES,
    parameter int SPR_W  = sprite_pixel_fetch_pkg::SPR_W,
    parameter int SPR_H  = sprite_pixel_fetch_pkg::SPR_H,
    parameter int STRIDE = sprite_pixel_fetch_pkg::ORIENT_STRIDE
) (
    input  logic        active,
    input  logic        en,
    input  logic [18:0] pix_addr,
    input  logic [18:0] start,
    input  logic [1:0]  orient,
    output logic        hit,
    output logic [18:0] sprite_addr
);

    logic [18:0] offset;
    logic [18:0] row;
    logic [18:0] col;
    logic        clip_ok;

    assign offset  = pix_addr - start;
    assign row     = offset / 19'(H_RES);
    assign col     = offset % 19'(H_RES);
    assign clip_ok = (pix_addr % 19'(H_RES)) >= (start % 19'(H_RES));

    assign hit = active && en && (pix_addr >= start) &&
                 (row < 19'(SPR_H)) && (col < 19'(SPR_W)) && clip_ok;

    assign sprite_addr = 19'(orient) * 19'(STRIDE) + row * 19'(SPR_W) + col;

endmodule

// File: rtl/sprite_pixel_fetch.sv
// Two-stage sprite pixel pipeline: hit test + ROM read, then color select and hit counting.
// Optional feature macro: SPRITE_TRANSPARENCY_EN.
module sprite_pixel_fetch
    import sprite_pixel_fetch_pkg::*;
#(
    parameter int H_RES   = sprite_pixel_fetch_pkg::H_RES,
    parameter int SPR_W   = sprite_pixel_fetch_pkg::SPR_W,
    parameter int SPR_H   = sprite_pixel_fetch_pkg::SPR_H,
    parameter int COLOR_W = 8
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               frame_start,
    input  logic               pix_valid,
    input  logic [18:0]        pix_addr,
    input  logic [18:0]        sprite_start,
    input  logic [1:0]         sprite_orient,
    input  logic               sprite_en,
    input  logic [COLOR_W-1:0] bg_color,
    output logic               rom_rd,
    output logic [18:0]        rom_addr,
    input  logic [COLOR_W-1:0] rom_data,
    output logic               out_valid,
    output logic [COLOR_W-1:0] out_color,
    output logic               out_hit,
    output logic [9:0]         hit_count
);

    localparam logic [9:0] HIT_MAX = 10'(SPR_W * SPR_H);

    frame_state_t state_q;
    frame_state_t state_d;

    logic [18:0]        shadow_start;
    logic [1:0]         shadow_orient;
    logic               shadow_en;
    logic               s0_hit;
    logic [18:0]        s0_addr;
    logic               s1_valid;
    logic [COLOR_W-1:0] s1_bg;
    logic               use_sprite;

    // NOTE: state_d takes its default first so no path through this block can infer a latch.
    always_comb begin
        state_d = state_q;
        if (state_q == IDLE && frame_start) begin
            state_d = ACTIVE;
        end
    end

    // NOTE: every register in the block updates with <= so all stages see pre-edge values.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q       <= IDLE;
            shadow_start  <= '0;
            shadow_orient <= '0;
            shadow_en     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (frame_start) begin
                shadow_start  <= sprite_start;
                shadow_orient <= sprite_orient;
                shadow_en     <= sprite_en;
            end
        end
    end

    sprite_addr_map #(
        .H_RES (H_RES),
        .SPR_W (SPR_W),
        .SPR_H (SPR_H),
        .STRIDE(SPR_W * SPR_H)
    ) u_addr_map (
        .active     (state_q == ACTIVE),
        .en         (shadow_en),
        .pix_addr   (pix_addr),
        .start      (shadow_start),
        .orient     (shadow_orient),
        .hit        (s0_hit),
        .sprite_addr(s0_addr)
    );

    // rom_rd doubles as the stage-1 hit flag.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            s1_valid <= 1'b0;
            s1_bg    <= '0;
            rom_rd   <= 1'b0;
            rom_addr <= '0;
        end else begin
            s1_valid <= pix_valid;
            s1_bg    <= bg_color;
            rom_rd   <= pix_valid && s0_hit;
            if (pix_valid && s0_hit) begin
                rom_addr <= s0_addr;
            end
        end
    end

`ifdef SPRITE_TRANSPARENCY_EN
    assign use_sprite = rom_rd && (rom_data != COLOR_W'(TRANSPARENT_KEY));
`else
    assign use_sprite = rom_rd;
`endif

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            out_valid <= 1'b0;
            out_hit   <= 1'b0;
            out_color <= '0;
        end else begin
            out_valid <= s1_valid;
            out_hit   <= use_sprite;
            out_color <= use_sprite ? rom_data : s1_bg;
        end
    end

    // A clear on frame_start wins over a same-cycle increment.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            hit_count <= '0;
        end else if (frame_start) begin
            hit_count <= '0;
        end else if (out_valid && out_hit && hit_count != HIT_MAX) begin
            hit_count <= hit_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_sprite_pixel_fetch.sv
// Scoreboard bench for sprite_pixel_fetch: stimulus pushes expectations, a monitor pops them.
// Expected hits come from a 2-D row/column model of the sprite rectangle.
module tb_sprite_pixel_fetch;

    localparam int H   = 640;
    localparam int W   = 30;
    localparam int HT  = 30;
    localparam int SAT = 900;
`ifdef SPRITE_TRANSPARENCY_EN
    localparam bit TRANSP = 1'b1;
`else
    localparam bit TRANSP = 1'b0;
`endif

    typedef struct packed {
        logic       hit;
        logic [7:0] color;
    } out_t;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        frame_start = 1'b0;
    logic        pix_valid = 1'b0;
    logic [18:0] pix_addr = '0;
    logic [18:0] sprite_start = '0;
    logic [1:0]  sprite_orient = '0;
    logic        sprite_en = 1'b0;
    logic [7:0]  bg_color = '0;
    logic        rom_rd;
    logic [18:0] rom_addr;
    logic [7:0]  rom_data;
    logic        out_valid;
    logic [7:0]  out_color;
    logic        out_hit;
    logic [9:0]  hit_count;

    bit   zero_rom = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   exp_cnt = 0;
    int   sh_start = 0;
    int   sh_orient = 0;
    bit   sh_en = 1'b0;
    bit   exp_active = 1'b0;
    out_t out_q[$];
    logic [18:0] rom_q[$];
    logic [18:0] mon_a;
    out_t mon_o;

    always #5 clock = ~clock;

    function automatic logic [7:0] rom_word(input logic [18:0] a);
        return {1'b1, a[6:0]};
    endfunction

    assign rom_data = zero_rom ? 8'h00 : rom_word(rom_addr);

    sprite_pixel_fetch dut (
        .clock        (clock),
        .resetn       (resetn),
        .frame_start  (frame_start),
        .pix_valid    (pix_valid),
        .pix_addr     (pix_addr),
        .sprite_start (sprite_start),
        .sprite_orient(sprite_orient),
        .sprite_en    (sprite_en),
        .bg_color     (bg_color),
        .rom_rd       (rom_rd),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data),
        .out_valid    (out_valid),
        .out_color    (out_color),
        .out_hit      (out_hit),
        .hit_count    (hit_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic bit model_hit(input int a);
        int pr, pc, sr, sc;
        pr = a / H;
        pc = a % H;
        sr = sh_start / H;
        sc = sh_start % H;
        return exp_active && sh_en && pr >= sr && pr < sr + HT && pc >= sc && pc < sc + W;
    endfunction

    function automatic logic [18:0] model_addr(input int a);
        return 19'(sh_orient * W * HT + (a / H - sh_start / H) * W + (a % H - sh_start % H));
    endfunction

    task automatic expect_pixel(input int a, input logic [7:0] bg);
        logic [18:0] ea;
        out_t e;
        e = {1'b0, bg};
        if (model_hit(a)) begin
            ea = model_addr(a);
            rom_q.push_back(ea);
            if (!(TRANSP && zero_rom)) begin
                e = {1'b1, zero_rom ? 8'h00 : rom_word(ea)};
                if (exp_cnt < SAT) exp_cnt++;
            end
        end
        out_q.push_back(e);
    endtask

    task automatic pixel(input int a, input logic [7:0] bg);
        pix_valid = 1'b1;
        pix_addr  = 19'(a);
        bg_color  = bg;
        expect_pixel(a, bg);
        @(negedge clock);
        pix_valid = 1'b0;
    endtask

    task automatic frame(input int st, input int ori, input bit en,
                         input bit with_pix, input int a, input logic [7:0] bg);
        frame_start   = 1'b1;
        sprite_start  = 19'(st);
        sprite_orient = 2'(ori);
        sprite_en     = en;
        exp_cnt       = 0;
        if (with_pix) begin
            pix_valid = 1'b1;
            pix_addr  = 19'(a);
            bg_color  = bg;
            expect_pixel(a, bg);
        end
        sh_start   = st;
        sh_orient  = ori;
        sh_en      = en;
        exp_active = 1'b1;
        @(negedge clock);
        frame_start = 1'b0;
        pix_valid   = 1'b0;
    endtask

    task automatic drain();
        repeat (4) @(negedge clock);
    endtask

    always @(negedge clock) begin
        if (resetn) begin
            if (rom_rd) begin
                if (rom_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rom_unexpected actual=%0d required=none", rom_addr);
                end else begin
                    mon_a = rom_q.pop_front();
                    check("rom_addr", 32'(rom_addr), 32'(mon_a));
                end
            end
            if (out_valid) begin
                if (out_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL out_unexpected actual=%0h required=none", {out_hit, out_color});
                end else begin
                    mon_o = out_q.pop_front();
                    check("out_hit_color", 32'({out_hit, out_color}), 32'(mon_o));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clock);
        check("rst_rom_rd",    32'(rom_rd),    0);
        check("rst_rom_addr",  32'(rom_addr),  0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_color", 32'(out_color), 0);
        check("rst_out_hit",   32'(out_hit),   0);
        check("rst_hit_count", 32'(hit_count), 0);
        resetn = 1'b1;
        @(negedge clock);

        // IDLE: pixels flow with background, no hits even with a pixel alongside frame_start
        sprite_start = '0;
        sprite_en    = 1'b1;
        pixel(0, 8'h33);
        frame(0, 0, 1'b1, 1'b1, 0, 8'h34);
        drain();

        // Two-cycle latency, top-left corner
        pixel(0, 8'h44);
        check("lat_rom_rd",    32'(rom_rd),    1);
        check("lat_rom_addr",  32'(rom_addr),  0);
        check("lat_out_valid", 32'(out_valid), 0);
        @(negedge clock);
        check("lat2_out_valid", 32'(out_valid), 1);
        check("lat2_out_hit",   32'(out_hit),   1);
        check("lat2_out_color", 32'(out_color), 32'h80);
        pixel(29, 8'h01);
        pixel(30, 8'h02);
        pixel(640, 8'h03);
        pixel(640 * 29 + 29, 8'h04);
        pixel(640 * 30, 8'h05);
        drain();
        check("cnt_frame_a", 32'(hit_count), 32'(exp_cnt));

        // Orientation 2, outside-left pixel, and sprite inputs changed mid-frame
        frame(6500, 2, 1'b1, 1'b0, 0, 8'h00);
        pixel(8427, 8'h10);
        pixel(6499, 8'h11);
        pixel(6500, 8'h12);
        sprite_start = '0;
        sprite_en    = 1'b0;
        pixel(0, 8'h13);
        drain();
        check("cnt_frame_b", 32'(hit_count), 32'(exp_cnt));

        // Right-edge clip; the pixel alongside frame_start still uses the old shadow
        frame(620, 0, 1'b1, 1'b1, 8427, 8'h20);
        pixel(645, 8'h21);
        pixel(1270, 8'h22);
        pixel(620, 8'h23);
        pixel(639, 8'h24);
        pixel(640, 8'h25);
        drain();
        check("cnt_frame_c", 32'(hit_count), 32'(exp_cnt));

        // Sprite window scan: 900 hits, then saturation, then clear collision
        frame(6500, 0, 1'b1, 1'b0, 0, 8'h00);
        drain();
        check("cnt_cleared", 32'(hit_count), 0);
        for (int r = 9; r <= 40; r++) begin
            for (int c = 98; c <= 131; c++) begin
                pixel(r * H + c, 8'(r + c));
            end
        end
        drain();
        check("cnt_full", 32'(hit_count), 900);
        pixel(6500, 8'h30);
        drain();
        check("cnt_saturate", 32'(hit_count), 900);
        pixel(6501, 8'h31);
        @(negedge clock);
        frame(6500, 0, 1'b1, 1'b0, 0, 8'h00);
        drain();
        check("cnt_clear_wins", 32'(hit_count), 0);

        // All-zero ROM word
        zero_rom = 1'b1;
        pixel(6501, 8'h77);
        drain();
        zero_rom = 1'b0;
        check("cnt_zero_word", 32'(hit_count), 32'(exp_cnt));

        // Reset with pixels in flight
        pix_valid = 1'b1;
        pix_addr  = 19'd6500;
        bg_color  = 8'h50;
        @(posedge clock);
        #1 pix_addr = 19'd6501;
        #1 resetn = 1'b0;
        pix_valid = 1'b0;
        exp_active = 1'b0;
        sh_start   = 0;
        sh_orient  = 0;
        sh_en      = 1'b0;
        exp_cnt    = 0;
        repeat (2) begin
            @(negedge clock);
            check("rrst_out_valid", 32'(out_valid), 0);
            check("rrst_rom_rd",    32'(rom_rd),    0);
        end
        check("rrst_hit_count", 32'(hit_count), 0);
        resetn = 1'b1;
        repeat (2) begin
            @(negedge clock);
            check("post_rst_out_valid", 32'(out_valid), 0);
        end
        sprite_start = '0;
        sprite_en    = 1'b1;
        pixel(0, 8'h60);
        pixel(6500, 8'h61);
        drain();
        check("idle_cnt", 32'(hit_count), 0);
        frame(0, 1, 1'b1, 1'b0, 0, 8'h00);
        pixel(5, 8'h62);
        drain();
        check("recover_cnt", 32'(hit_count), 1);

        check("rom_q_empty", 32'(rom_q.size()), 0);
        check("out_q_empty", 32'(out_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
